fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction block ROM: it drives the ROM enable and word address and consumes the ROM's registered read data.
- It delivers instruction/PC pairs to decode over a valid/ready handshake, one instruction per cycle when not stalled.
- It handles control-flow redirects and flags misaligned redirect targets.
- It relies on the ROM's 1-cycle registered read, where i_en=0 holds the data register.

Parameters:
- AW, 10, ROM word-address width; ROM covers 2**AW 32-bit words.
- DW, 32, instruction width; must equal ROM DW.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_rom_en  out  1  ROM read enable.
- o_rom_addr  out  AW  ROM word address.
- i_rom_data  in  DW  ROM registered read data.
- i_redirect  in  1  redirect request (branch/jump/trap), single-cycle pulse or level.
- i_redirect_pc  in  32  redirect target byte address.
- o_valid  out  1  o_instr/o_pc hold a valid fetched instruction.
- i_ready  in  1  decode accepts this cycle.
- o_instr  out  DW  instruction; wired directly from i_rom_data.
- o_pc  out  32  byte address of o_instr.
- o_fault  out  1  misaligned redirect target latched; fetch halted.

Behaviour:
- State: r_pc (next fetch address), r_rsp_pc (PC of the word in the ROM data register), r_rsp_valid, FSM {S_BOOT, S_RUN, S_FAULT}.
- Reset (async, i_rst_n=0):
  - state=S_BOOT; r_pc=RESET_PC; r_rsp_pc=RESET_PC; r_rsp_valid=0.
  - Outputs: o_valid=0, o_fault=0, o_rom_en=0, o_pc=RESET_PC.
- S_BOOT: lasts exactly one cycle after reset release, with no fetch issued; then go to S_RUN.
- S_RUN, normal flow:
  - advance = !r_rsp_valid || i_ready.
  - o_rom_en = advance; o_rom_addr = r_pc[AW+1:2].
  - On advance: r_rsp_pc<=r_pc; r_rsp_valid<=1; r_pc<=r_pc+4.
  - When not advancing, the ROM data register holds, so o_instr stays stable while o_valid && !i_ready.
- Latency:
  - Fetch issue to o_valid is 1 cycle.
  - Sustained throughput is 1 instruction per cycle with i_ready=1.
  - First o_valid is 2 cycles after reset release.
- Redirect (S_RUN or S_FAULT, i_redirect=1) has priority over everything else:
  - Aligned target (i_redirect_pc[1:0]==0):
    - o_rom_en=1; o_rom_addr=i_redirect_pc[AW+1:2].
    - r_rsp_pc<=i_redirect_pc; r_rsp_valid<=1; r_pc<=i_redirect_pc+4; state<=S_RUN; o_fault<=0.
    - The target appears on o_pc the next cycle.
    - Any o_valid&&i_ready on the redirect cycle is void: the in-flight/presented word is discarded, and the consumer must ignore it.
  - Misaligned target:
    - o_rom_en=0; r_rsp_valid<=0; r_rsp_pc<=i_redirect_pc; state<=S_FAULT; o_fault<=1.
- S_FAULT:
  - o_rom_en=0, o_valid=0, o_fault=1.
  - Left only by an aligned redirect.
  - A further misaligned redirect stays in S_FAULT and updates r_rsp_pc, so o_pc shows the faulting address.
- Redirect in S_BOOT is ignored; the boot fetch always starts at RESET_PC.
- Address arithmetic:
  - r_pc is 32-bit and wraps modulo 2**32.
  - The ROM address uses r_pc[AW+1:2] only, so PCs beyond ROM size alias: PC 2**(AW+2) reads word 0, while o_pc carries the full 32-bit value.
- Output mapping: o_valid=r_rsp_valid; o_pc=r_rsp_pc; o_instr=i_rom_data.
- Registered outputs and timing:
  - o_valid, o_pc and o_fault are registered.
  - o_rom_en and o_rom_addr are combinational from state, i_ready and i_redirect.
- Reset mid-operation: immediate return to reset values regardless of state; an outstanding fetch is dropped.

Test Plan:
- Reset release, i_ready=1, ROM word k = 32'h1000_0000+k -> o_valid first high in cycle 2 with o_pc=0, o_instr=32'h1000_0000; then o_pc=4,8,12 on consecutive cycles.
- Stall: hold i_ready=0 for 3 cycles while o_pc=8 -> o_rom_en=0, and o_instr/o_pc stay stable at 32'h1000_0002/8; when i_ready=1 returns, the next o_pc=12 with no skipped or duplicated word.
- Redirect to 32'h40 while streaming -> o_rom_addr=16 that cycle; next cycle o_valid=1, o_pc=32'h40, o_instr=32'h1000_0010; then o_pc=32'h44.
- Redirect to 32'h42 -> o_fault=1, o_valid=0, o_pc=32'h42, o_rom_en=0 indefinitely; a later redirect to 32'h80 clears o_fault and the next o_pc=32'h80.
- With AW=10, redirect to 32'h0000_0FFC -> o_pc=32'hFFC (word 1023), then o_pc=32'h1000 with o_instr equal to ROM word 0.
- Assert i_rst_n=0 mid-stream with o_valid=1 and i_ready=0 -> o_valid=0 immediately without waiting for a clock edge; after release the fetch sequence restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the block ROM read port and presents
// instruction/PC pairs to decode over valid/ready, with redirect and misalignment fault.
module fetch_unit #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_rom_en,
  output logic [AW-1:0] o_rom_addr,
  input  logic [DW-1:0] i_rom_data,
  input  logic          i_redirect,
  input  logic [31:0]   i_redirect_pc,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_instr,
  output logic [31:0]   o_pc,
  output logic          o_fault
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FAULT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] r_pc, r_pc_nxt;
  logic [31:0] r_rsp_pc, r_rsp_pc_nxt;
  logic        r_rsp_valid, r_rsp_valid_nxt;
  logic        r_fault, r_fault_nxt;
  logic        advance;
  logic        redir_aligned;

  assign advance       = !r_rsp_valid || i_ready;
  assign redir_aligned = (i_redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_nxt       = state;
    r_pc_nxt        = r_pc;
    r_rsp_pc_nxt    = r_rsp_pc;
    r_rsp_valid_nxt = r_rsp_valid;
    r_fault_nxt     = r_fault;
    o_rom_en        = 1'b0;
    o_rom_addr      = r_pc[AW+1:2];

    case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
      end

      S_RUN, S_FAULT: begin
        if (i_redirect) begin
          // Redirect wins over stalls; any word presented this cycle is void.
          if (redir_aligned) begin
            o_rom_en        = 1'b1;
            o_rom_addr      = i_redirect_pc[AW+1:2];
            r_rsp_pc_nxt    = i_redirect_pc;
            r_rsp_valid_nxt = 1'b1;
            r_pc_nxt        = i_redirect_pc + 32'd4;
            r_fault_nxt     = 1'b0;
            state_nxt       = S_RUN;
          end else begin
            r_rsp_pc_nxt    = i_redirect_pc;
            r_rsp_valid_nxt = 1'b0;
            r_fault_nxt     = 1'b1;
            state_nxt       = S_FAULT;
          end
        end else if (state == S_RUN && advance) begin
          o_rom_en        = 1'b1;
          r_rsp_pc_nxt    = r_pc;
          r_rsp_valid_nxt = 1'b1;
          r_pc_nxt        = r_pc + 32'd4;
        end
      end

      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_BOOT;
      r_pc        <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      state       <= state_nxt;
      r_pc        <= r_pc_nxt;
      r_rsp_pc    <= r_rsp_pc_nxt;
      r_rsp_valid <= r_rsp_valid_nxt;
      r_fault     <= r_fault_nxt;
    end
  end

  // While stalled the ROM is not enabled, so its data register keeps o_instr stable.
  assign o_valid = r_rsp_valid;
  assign o_pc    = r_rsp_pc;
  assign o_instr = i_rom_data;
  assign o_fault = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM, PC scoreboard checked on every accepted word,
// plus directed checks for stall, redirect, fault, aliasing and reset.
module tb_fetch_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          i_clk;
  logic          i_rst_n;
  logic          o_rom_en;
  logic [AW-1:0] o_rom_addr;
  logic [DW-1:0] i_rom_data;
  logic          i_redirect;
  logic [31:0]   i_redirect_pc;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_instr;
  logic [31:0]   o_pc;
  logic          o_fault;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [31:0] sb[$];

  fetch_unit #(
    .AW(AW),
    .DW(DW),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .o_rom_en(o_rom_en),
    .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_instr(o_instr),
    .o_pc(o_pc),
    .o_fault(o_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ROM word k holds 32'h1000_0000 + k; enable low holds the data register.
  always @(posedge i_clk) begin
    if (o_rom_en) i_rom_data <= 32'h1000_0000 + 32'(o_rom_addr);
  end

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {22'b0, pc[11:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
  endtask

  // Called just after a negedge with inputs for the coming edge already driven.
  task automatic tick();
    logic [31:0] exp_pc;
    #1;
    if (o_valid && i_ready && !i_redirect) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", o_pc, 32'hFFFF_FFFF);
      end else begin
        exp_pc = sb.pop_front();
        check("sb_pc", o_pc, exp_pc);
        check("sb_instr", o_instr, rom_word(exp_pc));
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    i_rst_n       = 1'b0;
    i_ready       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_fault", 32'(o_fault), 0);
    check("rst_rom_en", 32'(o_rom_en), 0);
    check("rst_pc", o_pc, 32'h0);

    // Boot and stream
    push_seq(32'h0, 20);
    i_rst_n = 1'b1;
    tick();
    check("boot_valid_c1", 32'(o_valid), 0);
    check("boot_rom_en_c1", 32'(o_rom_en), 1);
    tick();
    check("boot_valid_c2", 32'(o_valid), 1);
    check("boot_pc_c2", o_pc, 32'h0);
    check("boot_instr_c2", o_instr, 32'h1000_0000);
    tick();
    check("stream_pc4", o_pc, 32'h4);
    tick();
    check("stream_pc8", o_pc, 32'h8);

    // Stall at pc=8
    i_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("stall_rom_en", 32'(o_rom_en), 0);
      tick();
      check("stall_valid", 32'(o_valid), 1);
      check("stall_pc", o_pc, 32'h8);
      check("stall_instr", o_instr, 32'h1000_0002);
    end
    i_ready = 1'b1;
    tick();
    check("unstall_pc", o_pc, 32'hC);
    tick();
    tick();

    // Aligned redirect while streaming
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h40;
    #1;
    check("redir_rom_en", 32'(o_rom_en), 1);
    check("redir_rom_addr", 32'(o_rom_addr), 32'd16);
    sb.delete();
    push_seq(32'h40, 20);
    tick();
    i_redirect = 1'b0;
    check("redir_valid", 32'(o_valid), 1);
    check("redir_pc", o_pc, 32'h40);
    check("redir_instr", o_instr, 32'h1000_0010);
    tick();
    check("redir_next_pc", o_pc, 32'h44);
    tick();

    // Misaligned redirect -> fault
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h42;
    #1;
    check("mis_rom_en", 32'(o_rom_en), 0);
    sb.delete();
    tick();
    i_redirect = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      check("fault_flag", 32'(o_fault), 1);
      check("fault_valid", 32'(o_valid), 0);
      check("fault_pc", o_pc, 32'h42);
      check("fault_rom_en", 32'(o_rom_en), 0);
      tick();
    end
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h45;
    tick();
    i_redirect = 1'b0;
    check("fault_repc", o_pc, 32'h45);
    check("fault_still", 32'(o_fault), 1);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h80;
    push_seq(32'h80, 20);
    tick();
    i_redirect = 1'b0;
    check("unfault_flag", 32'(o_fault), 0);
    check("unfault_valid", 32'(o_valid), 1);
    check("unfault_pc", o_pc, 32'h80);
    tick();
    tick();

    // ROM aliasing past the last word
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0FFC;
    sb.delete();
    push_seq(32'h0000_0FFC, 20);
    tick();
    i_redirect = 1'b0;
    check("alias_pc_last", o_pc, 32'hFFC);
    check("alias_instr_last", o_instr, 32'h1000_03FF);
    tick();
    check("alias_pc_wrap", o_pc, 32'h1000);
    check("alias_instr_wrap", o_instr, 32'h1000_0000);
    tick();

    // Async reset mid-stream while stalled
    i_ready = 1'b0;
    tick();
    check("prerst_valid", 32'(o_valid), 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 0);
    check("async_rst_pc", o_pc, 32'h0);
    @(negedge i_clk);
    sb.delete();
    push_seq(32'h0, 20);
    i_ready = 1'b1;
    i_rst_n = 1'b1;
    // Redirect during the boot cycle must be ignored
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    check("reboot_valid_c1", 32'(o_valid), 0);
    tick();
    check("reboot_valid_c2", 32'(o_valid), 1);
    check("reboot_pc", o_pc, 32'h0);
    tick();
    check("reboot_pc4", o_pc, 32'h4);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
